// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// div_pkg : shared FSM encoding and sizing constants for div_reconstruct
// Rev 1.0
// ============================================================================
package div_pkg;

  localparam int c_default_width = 16;
  localparam int c_latency       = c_default_width + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_shift_add_mul.sv
`default_nettype none
// ============================================================================
// div_shift_add_mul : radix-2 shift-add unsigned multiplier, one bit per cycle
// Rev 1.0
// ============================================================================
module div_shift_add_mul import div_pkg::*; #(
  parameter int WIDTH = c_default_width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int                 c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_busy) begin
        r_mcand  <= {{WIDTH{1'b0}}, mcand};
        r_mplier <= mplier;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/div_reconstruct.sv
`default_nettype none
// ============================================================================
// div_reconstruct : dividend = quotient*divisor + remainder (signed, iterative)
// Optional range check on the exact sum: define DIV_RECONSTRUCT_OVF_EN.
// Rev 1.0
// ============================================================================
module div_reconstruct import div_pkg::*; #(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dividend,
  output logic             overflow
);

  div_state_t r_state;
  div_state_t w_state_next;

  logic               w_accept;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_mag_q;
  logic [WIDTH-1:0]   w_mag_d;
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH:0]   w_sum;

  logic               r_neg;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dividend;

  assign w_accept = (r_state == IDLE) && start;

  // Plain negation keeps -2^(WIDTH-1) intact as an unsigned magnitude.
  assign w_mag_q = quotient[WIDTH-1] ? -quotient : quotient;
  assign w_mag_d = divisor[WIDTH-1]  ? -divisor  : divisor;

  div_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_accept),
    .mcand   (w_mag_q),
    .mplier  (w_mag_d),
    .done    (w_mul_done),
    .product (w_prod_mag)
  );

  assign w_prod_s = r_neg ? -w_prod_mag : w_prod_mag;
  assign w_sum    = {w_prod_s[2*WIDTH-1], w_prod_s}
                  + {{(WIDTH+1){r_rem[WIDTH-1]}}, r_rem};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = MUL;
      end
      MUL:  if (w_mul_done) w_state_next = ADD;
      ADD:  w_state_next = DONE;
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg      <= 1'b0;
      r_rem      <= '0;
      r_dividend <= '0;
    end else begin
      if (w_accept) begin
        r_neg <= quotient[WIDTH-1] ^ divisor[WIDTH-1];
        r_rem <= remainder;
      end
      if (r_state == ADD) begin
        r_dividend <= w_sum[WIDTH-1:0];
      end
    end
  end

  assign dividend = r_dividend;

`ifdef DIV_RECONSTRUCT_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // In range exactly when every bit above the result sign copies it.
  assign w_ovf = (w_sum[2*WIDTH:WIDTH-1] != '0) && (w_sum[2*WIDTH:WIDTH-1] != '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ADD) begin
      r_ovf <= w_ovf;
    end
  end

  assign overflow = r_ovf;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_sum[2*WIDTH:WIDTH];
  assign overflow    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_reconstruct.sv
`default_nettype none
// ============================================================================
// tb_div_reconstruct : directed scoreboard bench for div_reconstruct
// Rev 1.0
// ============================================================================
module tb_div_reconstruct;

  localparam int W   = 16;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] quotient;
  logic [W-1:0] divisor;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic [W-1:0] dividend;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] div;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_reconstruct #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dividend  (dividend),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int q, input int d, input int r);
    longint full;
    exp_t   e;
    full  = longint'(q) * longint'(d) + longint'(r);
    e.div = full[W-1:0];
`ifdef DIV_RECONSTRUCT_OVF_EN
    e.ovf = (full < -(longint'(1) <<< (W-1))) || (full > (longint'(1) <<< (W-1)) - 1);
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Drive one start pulse; operands are scrambled right after the accepting edge.
  task automatic pulse_start(input int q, input int d, input int r, input bit push);
    @(negedge clk);
    quotient  = W'(q);
    divisor   = W'(d);
    remainder = W'(r);
    start     = 1'b1;
    if (push) sb.push_back(model(q, d, r));
    @(posedge clk);
    #1;
    start     = 1'b0;
    quotient  = W'($urandom);
    divisor   = W'($urandom);
    remainder = W'($urandom);
  endtask

  task automatic run_op(input string tag, input int q, input int d, input int r);
    int   lat;
    exp_t e;
    pulse_start(q, d, r, 1'b1);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (done !== 1'b1 && lat < 40);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'(LAT));
    chk({tag, ".sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".dividend"}, 32'(dividend), 32'(e.div));
      chk({tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
      @(posedge clk);
      #1;
      chk({tag, ".pulse"}, 32'(done), 32'd0);
      chk({tag, ".held"}, 32'(dividend), 32'(e.div));
      chk({tag, ".idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int   ndone;
    int   lat;
    exp_t e;

    rst       = 1'b1;
    start     = 1'b0;
    quotient  = '0;
    divisor   = '0;
    remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.dividend", 32'(dividend), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("pos_pos", 6, 5, 2);
    run_op("neg_pos", -6, 5, -2);
    run_op("neg_neg", -6, -5, 2);
    run_op("div_zero", 7, 0, 3);
    run_op("q_zero", 0, -9, -4);
    run_op("min_neg1", -32768, -1, 0);
    run_op("wrap", 300, 300, 0);

    // Re-pulsed start while busy must neither restart nor queue.
    pulse_start(100, -3, 7, 1'b1);
    ndone = 0;
    lat   = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          lat = c;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("repulse.dividend", 32'(dividend), 32'(e.div));
            chk("repulse.overflow", 32'(overflow), 32'(e.ovf));
          end
        end
      end
      if (c == 2 || c == 9) begin
        start     = 1'b1;
        quotient  = W'(-1234);
        divisor   = W'(77);
        remainder = W'(11);
      end else begin
        start = 1'b0;
      end
    end
    chk("repulse.ndone", 32'(ndone), 32'd1);
    chk("repulse.lat", 32'(lat), 32'(LAT));
    chk("repulse.sb", 32'(sb.size()), 32'd0);

    // Reset mid-operation discards the result.
    pulse_start(1234, 5, 6, 1'b0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.dividend", 32'(dividend), 32'd0);
    chk("abort.overflow", 32'(overflow), 32'd0);
    ndone = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort.ndone", 32'(ndone), 32'd0);
    run_op("after_abort", -1000, 30, -5);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst       = 1'b1;
    start     = 1'b1;
    quotient  = W'(3);
    divisor   = W'(4);
    remainder = W'(5);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start.busy", 32'(busy), 32'd0);
    ndone = 0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("rst_start.ndone", 32'(ndone), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
